sd_req_arbiter: RTL and testbench

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

---
 rtl/sd_req_arbiter_if.sv | 38 +++
 rtl/sd_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_req_arbiter_if.sv
// Drive-side and host-side signal bundle for sd_req_arbiter.
// The master modport is the environment side, the slave modport is the arbiter.
interface sd_req_arbiter_if #(
  parameter int DRIVES = 2
);
  localparam int NDR = (DRIVES < 1) ? 1 : (DRIVES > 4) ? 4 : DRIVES;
  localparam int N   = NDR - 1;

  logic [N:0]  drv_rd;
  logic [N:0]  drv_wr;
  logic [31:0] drv_lba      [NDR];
  logic [5:0]  drv_blk_cnt  [NDR];
  logic [7:0]  drv_buff_din [NDR];
  logic [N:0]  drv_ack;

  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;

  logic [N:0]  grant;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, sd_ack,
    output drv_ack, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
           grant, busy, timeout_err
  );

  modport master (
    output drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, sd_ack,
    input  drv_ack, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
           grant, busy, timeout_err
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter funnelling up to four drive sector requests onto one
// SD host port, with abort on request withdrawal and an issue timeout.
module sd_req_arbiter #(
  parameter int          DRIVES  = 2,
  parameter logic [23:0] TIMEOUT = 24'd16777215
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  sd_req_arbiter_if.slave bus
);
  localparam int NDR = (DRIVES < 1) ? 1 : (DRIVES > 4) ? 4 : DRIVES;
  localparam int N   = NDR - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gidx_q, gidx_d;
  logic        gvld_q, gvld_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic [31:0] lba_q, lba_d;
  logic [5:0]  blk_q, blk_d;
  logic [23:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [1:0]  rst_sync_q;

  logic [3:0]  rd4, req4;
  logic [31:0] lba4 [4];
  logic [5:0]  blk4 [4];
  logic [7:0]  din4 [4];
  logic [N:0]  grant_w;
  logic        sel_vld;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic        tmo_hit;
  logic        ack_phase;

  // Pad the per-drive inputs to four lanes so indexing never leaves range.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < NDR) begin : g_act
      assign rd4[g]  = bus.drv_rd[g];
      assign req4[g] = bus.drv_rd[g] | bus.drv_wr[g];
      assign lba4[g] = bus.drv_lba[g];
      assign blk4[g] = bus.drv_blk_cnt[g];
      assign din4[g] = bus.drv_buff_din[g];
    end else begin : g_pad
      assign rd4[g]  = 1'b0;
      assign req4[g] = 1'b0;
      assign lba4[g] = '0;
      assign blk4[g] = '0;
      assign din4[g] = '0;
    end
  end

  assign ack_phase = (state_q == S_ISSUE) || (state_q == S_XFER);

  for (genvar g = 0; g < NDR; g++) begin : g_out
    assign grant_w[g]     = gvld_q && (gidx_q == 2'(g));
    assign bus.drv_ack[g] = ack_phase & bus.sd_ack & grant_w[g];
  end

  assign bus.grant       = grant_w;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_lba      = lba_q;
  assign bus.sd_blk_cnt  = blk_q;
  assign bus.sd_buff_din = gvld_q ? din4[gidx_q] : 8'h00;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.timeout_err = tmo_q;

  // Search starts one past the last served drive, so it loses priority.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = 2'((int'(ptr_q) + k) % NDR);
      if (k <= NDR && !sel_vld && req4[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign tmo_hit = ({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gvld_d  = gvld_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_sync_q[1] && sel_vld) begin
          state_d = S_ISSUE;
          gidx_d  = sel_idx;
          gvld_d  = 1'b1;
          sd_rd_d = rd4[sel_idx];
          sd_wr_d = ~rd4[sel_idx];
          lba_d   = lba4[sel_idx];
          blk_d   = blk4[sel_idx];
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = (cnt_q == 24'hFFFFFF) ? cnt_q : cnt_q + 24'd1;
        if (bus.sd_ack) begin
          state_d = S_XFER;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (!req4[gidx_q]) begin
          // Withdrawal before the host answered: drop quietly, keep ptr.
          state_d = S_IDLE;
          gvld_d  = 1'b0;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          gvld_d  = 1'b0;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          tmo_d   = 1'b1;
          ptr_d   = gidx_q;
        end
      end
      S_XFER: begin
        if (!bus.sd_ack) state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = gidx_q;
        gvld_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset asserts immediately but releases two clk_sys edges later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'(N);
      gidx_q  <= '0;
      gvld_q  <= 1'b0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      lba_q   <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gvld_q  <= gvld_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scenario bench for sd_req_arbiter with two drives and a short timeout,
// ending in a randomized run against a round-robin reference model.
`timescale 1ns/1ps
module tb_sd_req_arbiter;
  localparam int          NDR = 2;
  localparam logic [23:0] TMO = 24'd16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic [NDR-1:0] rd_v, wr_v;
  logic [31:0]    lba_v [NDR];
  logic [5:0]     blk_v [NDR];
  logic [7:0]     din_v [NDR];
  logic           sd_ack_v;

  int vectors     = 0;
  int miscompares = 0;

  sd_req_arbiter_if #(.DRIVES(NDR)) bus ();

  assign bus.drv_rd       = rd_v;
  assign bus.drv_wr       = wr_v;
  assign bus.drv_lba      = lba_v;
  assign bus.drv_blk_cnt  = blk_v;
  assign bus.drv_buff_din = din_v;
  assign bus.sd_ack       = sd_ack_v;

  sd_req_arbiter #(.DRIVES(NDR), .TIMEOUT(TMO)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Round-robin reference: first pending drive after the last one served.
  function automatic int rr_pick(input logic [NDR-1:0] pend, input int last);
    rr_pick = -1;
    for (int k = NDR; k >= 1; k--)
      if (pend[(last + k) % NDR]) rr_pick = (last + k) % NDR;
  endfunction

  task automatic apply_reset();
    reset_n  = 1'b0;
    rd_v     = '0;
    wr_v     = '0;
    sd_ack_v = 1'b0;
    for (int i = 0; i < NDR; i++) begin
      lba_v[i] = '0; blk_v[i] = '0; din_v[i] = '0;
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic wait_busy();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_sys);
      seen = bus.busy;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_busy: busy=0 after 40 cycles, required 1");
    end
  endtask

  task automatic serve(input int drv, input bit op_rd, input int len);
    bit idle_seen = 1'b0;
    sd_ack_v = 1'b1;
    repeat (len) begin
      @(negedge clk_sys);
      if (bus.drv_ack[drv]) begin
        if (op_rd) rd_v[drv] = 1'b0; else wr_v[drv] = 1'b0;
      end
    end
    sd_ack_v = 1'b0;
    for (int i = 0; i < 10 && !idle_seen; i++) begin
      @(negedge clk_sys);
      idle_seen = !bus.busy;
    end
    vectors++;
    if (!idle_seen) begin
      miscompares++;
      $display("FAIL serve_idle: busy=1 after 10 cycles, required 0");
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rd_v     = 2'b11; wr_v = 2'b00; sd_ack_v = 1'b0;
    lba_v[0] = 32'hAA; lba_v[1] = 32'hBB;
    blk_v[0] = 6'd5;   blk_v[1] = 6'd6;
    din_v[0] = 8'h5A;  din_v[1] = 8'hA5;
    @(negedge clk_sys);
    vectors++;
    if ({bus.busy, bus.grant, bus.sd_rd, bus.sd_wr, bus.drv_ack, bus.timeout_err} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/grant/rd/wr/ack/tmo=%b required 0",
               {bus.busy, bus.grant, bus.sd_rd, bus.sd_wr, bus.drv_ack, bus.timeout_err});
    end
    vectors++;
    if (bus.sd_lba !== 32'h0 || bus.sd_blk_cnt !== 6'h0 || bus.sd_buff_din !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: lba=%h blk=%h din=%h required 0", bus.sd_lba, bus.sd_blk_cnt, bus.sd_buff_din);
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_sys);
      vectors++;
      if (bus.busy !== (c == 3)) begin
        miscompares++;
        $display("FAIL reset_sync: cycle %0d busy=%b required %b", c, bus.busy, c == 3);
      end
    end
    vectors++;
    if (bus.grant !== 2'b01 || bus.sd_lba !== 32'hAA) begin
      miscompares++;
      $display("FAIL reset_first: grant=%b lba=%h required 01/000000aa", bus.grant, bus.sd_lba);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    lba_v[0] = 32'h10; lba_v[1] = 32'h20;
    blk_v[0] = 6'd1;   blk_v[1] = 6'd2;
    rd_v = 2'b11;
    wait_busy();
    vectors++;
    if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0 ||
        bus.sd_lba !== 32'h10 || bus.sd_blk_cnt !== 6'd1) begin
      miscompares++;
      $display("FAIL basic_first: grant=%b rd=%b wr=%b lba=%h blk=%0d required 01/1/0/10/1",
               bus.grant, bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.sd_blk_cnt);
    end
    serve(0, 1'b1, 3);
    wait_busy();
    vectors++;
    if (bus.grant !== 2'b10 || bus.sd_rd !== 1'b1 || bus.sd_lba !== 32'h20 || bus.sd_blk_cnt !== 6'd2) begin
      miscompares++;
      $display("FAIL basic_second: grant=%b rd=%b lba=%h blk=%0d required 10/1/20/2",
               bus.grant, bus.sd_rd, bus.sd_lba, bus.sd_blk_cnt);
    end
    serve(1, 1'b1, 2);
  endtask

  task automatic test_rd_wr();
    apply_reset();
    lba_v[0] = 32'h55; blk_v[0] = 6'd3;
    rd_v = 2'b01; wr_v = 2'b01;
    wait_busy();
    vectors++;
    if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0 || bus.sd_blk_cnt !== 6'd3) begin
      miscompares++;
      $display("FAIL rdwr_read: rd=%b wr=%b blk=%0d required 1/0/3", bus.sd_rd, bus.sd_wr, bus.sd_blk_cnt);
    end
    serve(0, 1'b1, 2);
    wait_busy();
    vectors++;
    if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b1 || bus.grant !== 2'b01) begin
      miscompares++;
      $display("FAIL rdwr_write: rd=%b wr=%b grant=%b required 0/1/01", bus.sd_rd, bus.sd_wr, bus.grant);
    end
    serve(0, 1'b0, 2);
  endtask

  task automatic test_fairness();
    int exp_tbl [3] = '{0, 1, 0};
    apply_reset();
    rd_v = 2'b11;
    for (int g = 0; g < 3; g++) begin
      wait_busy();
      vectors++;
      if (bus.grant !== (2'b01 << exp_tbl[g])) begin
        miscompares++;
        $display("FAIL fair_grant%0d: grant=%b required drive %0d", g, bus.grant, exp_tbl[g]);
      end
      serve(exp_tbl[g], 1'b1, 1);
      rd_v[0] = 1'b1;
    end
    rd_v = '0;
  endtask

  task automatic test_stale_ack();
    apply_reset();
    sd_ack_v = 1'b1;
    rd_v = 2'b01;
    wait_busy();
    vectors++;
    if (bus.drv_ack !== 2'b01 || bus.sd_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_issue: drv_ack=%b rd=%b required 01/1", bus.drv_ack, bus.sd_rd);
    end
    rd_v = 2'b00;
    @(negedge clk_sys);
    vectors++;
    if (bus.sd_rd !== 1'b0 || bus.busy !== 1'b1 || bus.drv_ack !== 2'b01) begin
      miscompares++;
      $display("FAIL stale_xfer: rd=%b busy=%b drv_ack=%b required 0/1/01", bus.sd_rd, bus.busy, bus.drv_ack);
    end
    serve(0, 1'b1, 1);
    rd_v = 2'b11;
    wait_busy();
    vectors++;
    if (bus.grant !== 2'b10) begin
      miscompares++;
      $display("FAIL stale_ptr: grant=%b required 10", bus.grant);
    end
  endtask

  task automatic test_timeout();
    int  n   = 1;
    bit  bad = 1'b0;
    bit  stop = 1'b0;
    apply_reset();
    rd_v = 2'b11;
    wait_busy();
    for (int i = 0; i < 40 && !stop; i++) begin
      @(negedge clk_sys);
      if (bus.sd_rd) begin
        n++;
        if (bus.drv_ack !== 2'b00 || bus.timeout_err !== 1'b0) bad = 1'b1;
      end else stop = 1'b1;
    end
    vectors++;
    if (n != 16 || bad) begin
      miscompares++;
      $display("FAIL tmo_len: issue cycles=%0d glitch=%b required 16/0", n, bad);
    end
    vectors++;
    if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_pulse: timeout_err=%b busy=%b required 1/0", bus.timeout_err, bus.busy);
    end
    @(negedge clk_sys);
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.grant !== 2'b10 || bus.sd_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_next: timeout_err=%b grant=%b rd=%b required 0/10/1",
               bus.timeout_err, bus.grant, bus.sd_rd);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    rd_v = 2'b01;
    wait_busy();
    rd_v = 2'b00;
    @(negedge clk_sys);
    vectors++;
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.sd_rd !== 1'b0 ||
        bus.drv_ack !== 2'b00 || bus.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_abort: busy=%b grant=%b rd=%b ack=%b tmo=%b required 0/00/0/00/0",
               bus.busy, bus.grant, bus.sd_rd, bus.drv_ack, bus.timeout_err);
    end
    rd_v = 2'b11;
    wait_busy();
    vectors++;
    if (bus.grant !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_ptr: grant=%b required 01", bus.grant);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rd_v = 2'b01;
    wait_busy();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.sd_rd !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_issue: rd=%b grant=%b busy=%b required 0/00/0", bus.sd_rd, bus.grant, bus.busy);
    end
    apply_reset();
    rd_v = 2'b01;
    wait_busy();
    sd_ack_v = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if (bus.drv_ack !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_pre: drv_ack=%b required 01", bus.drv_ack);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0 || bus.grant !== 2'b00 ||
        bus.drv_ack !== 2'b00 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_xfer: rd=%b wr=%b grant=%b ack=%b busy=%b required all 0",
               bus.sd_rd, bus.sd_wr, bus.grant, bus.drv_ack, bus.busy);
    end
    sd_ack_v = 1'b0;
  endtask

  task automatic test_long_ack();
    int bad_ack = 0;
    int bad_din = 0;
    apply_reset();
    rd_v = 2'b10;
    wait_busy();
    vectors++;
    if (bus.grant !== 2'b10 || bus.drv_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL long_grant: grant=%b drv_ack=%b required 10/00", bus.grant, bus.drv_ack);
    end
    sd_ack_v = 1'b1;
    din_v[0] = 8'($urandom); din_v[1] = 8'($urandom);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk_sys);
      if (bus.drv_ack !== 2'b10) bad_ack++;
      if (bus.sd_buff_din !== din_v[1]) bad_din++;
      rd_v[1]  = 1'b0;
      din_v[0] = 8'($urandom); din_v[1] = 8'($urandom);
    end
    sd_ack_v = 1'b0;
    vectors++;
    if (bad_ack != 0 || bad_din != 0) begin
      miscompares++;
      $display("FAIL long_ack: %0d ack cycles off, %0d data cycles off, required 0/0", bad_ack, bad_din);
    end
    @(negedge clk_sys);
    vectors++;
    if (bus.drv_ack !== 2'b00 || bus.sd_buff_din !== din_v[1]) begin
      miscompares++;
      $display("FAIL long_end: drv_ack=%b din=%h required 00/%h", bus.drv_ack, bus.sd_buff_din, din_v[1]);
    end
  endtask

  task automatic test_random();
    int             last, owner, exp, ack_wait, ack_left;
    bit             owner_vld, own_rd;
    logic [31:0]    exp_lba;
    logic [5:0]     exp_blk;
    logic [NDR-1:0] onehot;
    apply_reset();
    last = NDR - 1; owner = 0; owner_vld = 0; own_rd = 0;
    ack_wait = 0; ack_left = 0; exp_lba = '0; exp_blk = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_sys);
      if (bus.busy && !owner_vld) begin
        exp = rr_pick(rd_v | wr_v, last);
        vectors++;
        if (exp < 0) begin
          miscompares++;
          $display("FAIL rnd_spurious: grant=%b with nothing pending", bus.grant);
          owner = 0;
        end else owner = exp;
        owner_vld = 1'b1;
        own_rd    = rd_v[owner];
        exp_lba   = lba_v[owner];
        exp_blk   = blk_v[owner];
        vectors++;
        if (bus.sd_rd !== own_rd || bus.sd_wr !== !own_rd) begin
          miscompares++;
          $display("FAIL rnd_op: rd=%b wr=%b required rd=%b", bus.sd_rd, bus.sd_wr, own_rd);
        end
        ack_wait = $urandom_range(0, 3);
        ack_left = $urandom_range(1, 5);
      end else if (!bus.busy && owner_vld) begin
        owner_vld = 1'b0;
        last      = owner;
      end
      onehot = owner_vld ? ({{(NDR-1){1'b0}}, 1'b1} << owner) : '0;
      vectors++;
      if (bus.grant !== onehot) begin
        miscompares++;
        $display("FAIL rnd_grant: cycle %0d grant=%b required %b", cyc, bus.grant, onehot);
      end
      vectors++;
      if (bus.sd_buff_din !== (owner_vld ? din_v[owner] : 8'h00)) begin
        miscompares++;
        $display("FAIL rnd_din: cycle %0d din=%h required %h", cyc, bus.sd_buff_din,
                 owner_vld ? din_v[owner] : 8'h00);
      end
      vectors++;
      if ((bus.sd_rd && bus.sd_wr) || (bus.drv_ack & ~onehot) != '0) begin
        miscompares++;
        $display("FAIL rnd_excl: cycle %0d rd=%b wr=%b drv_ack=%b owner=%b",
                 cyc, bus.sd_rd, bus.sd_wr, bus.drv_ack, onehot);
      end
      if (owner_vld) begin
        vectors++;
        if (bus.sd_lba !== exp_lba || bus.sd_blk_cnt !== exp_blk) begin
          miscompares++;
          $display("FAIL rnd_addr: cycle %0d lba=%h blk=%0d required %h/%0d",
                   cyc, bus.sd_lba, bus.sd_blk_cnt, exp_lba, exp_blk);
        end
        if (bus.drv_ack[owner]) begin
          if (own_rd) rd_v[owner] = 1'b0; else wr_v[owner] = 1'b0;
        end
        if (sd_ack_v) begin
          if (ack_left <= 1) begin sd_ack_v = 1'b0; ack_left = 0; end
          else ack_left--;
        end else if (ack_left > 0) begin
          if (ack_wait == 0) sd_ack_v = 1'b1; else ack_wait--;
        end
      end
      for (int i = 0; i < NDR; i++) begin
        din_v[i] = 8'($urandom);
        if (!rd_v[i] && !wr_v[i] && $urandom_range(0, 7) == 0) begin
          lba_v[i] = $urandom;
          blk_v[i] = 6'($urandom);
          case ($urandom_range(0, 3))
            0:       begin rd_v[i] = 1'b1; wr_v[i] = 1'b1; end
            1:       wr_v[i] = 1'b1;
            default: rd_v[i] = 1'b1;
          endcase
        end
      end
    end
    sd_ack_v = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_v = '0; wr_v = '0; sd_ack_v = 1'b0;
    for (int i = 0; i < NDR; i++) begin
      lba_v[i] = '0; blk_v[i] = '0; din_v[i] = '0;
    end
    test_reset();
    test_basic();
    test_rd_wr();
    test_fairness();
    test_stale_ack();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    test_long_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
